// File: rtl/step_pkg.sv
// Shared types and encodings for the adaptive step-size sequencer.
package step_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACC_ONE,
    ACC_TWO,
    EVAL,
    DIVIDE,
    REJECT,
    FAULT
  } step_state_e;

  localparam logic [1:0] COORD_ACC1 = 2'b00;
  localparam logic [1:0] COORD_ACC2 = 2'b01;
  localparam logic [1:0] COORD_EVAL = 2'b11;
  localparam logic [1:0] COORD_HOLD = 2'b10;

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_EXC   = 2'b01;
  localparam logic [1:0] FAULT_RETRY = 2'b10;
  localparam logic [1:0] FAULT_DIV   = 2'b11;

  // Phase code presented to the datapath while in a given state.
  function automatic logic [1:0] coord_of(step_state_e s);
    logic [1:0] c;
    c = COORD_HOLD;
    case (s)
      ACC_ONE:        c = COORD_ACC1;
      ACC_TWO:        c = COORD_ACC2;
      EVAL, DIVIDE:   c = COORD_EVAL;
      default:        c = COORD_HOLD;
    endcase
    return c;
  endfunction

  function automatic logic is_busy(step_state_e s);
    return (s != IDLE) && (s != FAULT);
  endfunction

endpackage

// File: rtl/step_watchdog.sv
// Loadable down-counter; used as the divider timeout and the EVAL settle delay.
module step_watchdog #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_expired_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired_c = (r_cnt == '0);

endmodule

// File: rtl/step_size_controller.sv
// Sequencing FSM for the adaptive step-size datapath: accumulate, evaluate,
// then either regrow h through the divider or halve it and retry.
module step_size_controller
  import step_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned MAX_RETRY   = 8,
  parameter int unsigned DIV_TIMEOUT = 40
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] hInit,
  input  logic             accDoneOne,
  input  logic             accDoneTwo,
  input  logic             compareGE,
  input  logic             divFinished,
  input  logic             exceptionErr,
  input  logic [WIDTH-1:0] hModified,
  input  logic [WIDTH-1:0] halfHStep,
  output logic [1:0]       coord,
  output logic             divEnable,
  output logic [WIDTH-1:0] hStep,
  output logic             incTime,
  output logic             stepFinish,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       faultCode,
  output logic [3:0]       retryCount
);

  localparam int unsigned CNT_W = $clog2(DIV_TIMEOUT + 1);

  step_state_e      r_state, w_state_n;
  logic [WIDTH-1:0] r_h, w_h_n;
  logic [3:0]       r_retry, w_retry_n;
  logic [1:0]       r_code, w_code_n;
  logic [1:0]       r_coord;
  logic             r_div_en, r_inc, r_fin, r_busy, r_fault;
  logic             w_inc_n, w_fin_n;
  logic             w_wd_load, w_wd_dec, w_wd_expired;
  logic [CNT_W-1:0] w_wd_val;

  step_watchdog #(.CNT_W(CNT_W)) u_watchdog (
    .clk         (Clk),
    .rst_n       (reset),
    .i_load      (w_wd_load),
    .i_load_val  (w_wd_val),
    .i_dec       (w_wd_dec),
    .o_expired_c (w_wd_expired)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_h      <= '0;
      r_retry  <= '0;
      r_code   <= FAULT_NONE;
      r_coord  <= COORD_HOLD;
      r_div_en <= 1'b0;
      r_inc    <= 1'b0;
      r_fin    <= 1'b0;
      r_busy   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_h      <= w_h_n;
      r_retry  <= w_retry_n;
      r_code   <= w_code_n;
      r_coord  <= coord_of(w_state_n);
      r_div_en <= (w_state_n == DIVIDE);
      r_inc    <= w_inc_n;
      r_fin    <= w_fin_n;
      r_busy   <= is_busy(w_state_n);
      r_fault  <= (w_state_n == FAULT);
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_h_n     = r_h;
    w_retry_n = r_retry;
    w_code_n  = r_code;
    w_inc_n   = 1'b0;
    w_fin_n   = 1'b0;
    w_wd_load = 1'b0;
    w_wd_val  = '0;
    w_wd_dec  = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          if (hInit == '0) begin
            w_state_n = FAULT;
            w_code_n  = FAULT_DIV;
          end else begin
            w_h_n     = hInit;
            w_retry_n = '0;
            w_state_n = ACC_ONE;
          end
        end
      end
      ACC_ONE: if (accDoneOne) w_state_n = ACC_TWO;
      ACC_TWO: begin
        if (accDoneTwo) begin
          w_state_n = EVAL;
          w_wd_load = 1'b1;
          w_wd_val  = CNT_W'(1);
        end
      end
      // First EVAL cycle drains the settle count; the verdict is taken on the second.
      EVAL: begin
        if (!w_wd_expired) begin
          w_wd_dec = 1'b1;
        end else if (compareGE) begin
          w_inc_n   = 1'b1;
          w_state_n = DIVIDE;
          w_wd_load = 1'b1;
          w_wd_val  = CNT_W'(DIV_TIMEOUT - 1);
        end else begin
          w_state_n = REJECT;
        end
      end
      DIVIDE: begin
        if (divFinished) begin
          if (hModified == '0) begin
            w_state_n = FAULT;
            w_code_n  = FAULT_DIV;
          end else begin
            w_h_n     = hModified;
            w_fin_n   = 1'b1;
            w_retry_n = '0;
            w_state_n = IDLE;
          end
        end else if (w_wd_expired) begin
          w_state_n = FAULT;
          w_code_n  = FAULT_DIV;
        end else begin
          w_wd_dec = 1'b1;
        end
      end
      // h is only replaced when the retry actually proceeds.
      REJECT: begin
        w_retry_n = r_retry + 4'd1;
        if (halfHStep == '0) begin
          w_state_n = FAULT;
          w_code_n  = FAULT_DIV;
        end else if ((r_retry + 4'd1) == 4'(MAX_RETRY)) begin
          w_state_n = FAULT;
          w_code_n  = FAULT_RETRY;
        end else begin
          w_h_n     = halfHStep;
          w_state_n = ACC_ONE;
        end
      end
      default: w_state_n = FAULT;
    endcase

    // Datapath exceptions pre-empt every other transition out of a busy state.
    if (is_busy(r_state) && exceptionErr) begin
      w_state_n = FAULT;
      w_code_n  = FAULT_EXC;
      w_h_n     = r_h;
      w_retry_n = r_retry;
      w_inc_n   = 1'b0;
      w_fin_n   = 1'b0;
      w_wd_load = 1'b0;
      w_wd_dec  = 1'b0;
    end
  end

  assign coord      = r_coord;
  assign divEnable  = r_div_en;
  assign hStep      = r_h;
  assign incTime    = r_inc;
  assign stepFinish = r_fin;
  assign busy       = r_busy;
  assign fault      = r_fault;
  assign faultCode  = r_code;
  assign retryCount = r_retry;

endmodule
